// File: rtl/alu_iq_pkg.sv
// Shared types and constants for the ALU issue queue and its oldest-ready picker.
package alu_iq_pkg;

   localparam int ROB_IDX_W = 3;
   localparam int IQ_DEPTH  = 4;

   // One reservation slot: op fields, destination tag and both source operands.
   typedef struct packed {
      logic                 valid;
      logic [4:0]           opcode;
      logic [2:0]           funct3;
      logic                 funct7;
      logic [31:0]          imm;
      logic [15:0]          pc;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic                 src1_rdy;
      logic [ROB_IDX_W-1:0] src1_tag;
      logic [31:0]          src1_data;
      logic                 src2_rdy;
      logic [ROB_IDX_W-1:0] src2_tag;
      logic [31:0]          src2_data;
   } iq_entry_t;

   // The subset of an entry that travels to the ALU when it issues.
   typedef struct packed {
      logic [4:0]           opcode;
      logic [2:0]           funct3;
      logic                 funct7;
      logic [31:0]          imm;
      logic [15:0]          pc;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [31:0]          rs1_data;
      logic [31:0]          rs2_data;
   } iss_payload_t;

   // Distance from the ROB head; the 3-bit subtraction wraps naturally.
   function automatic logic [ROB_IDX_W-1:0] rob_age(input logic [ROB_IDX_W-1:0] rob_idx,
                                                    input logic [ROB_IDX_W-1:0] rob_head);
      return rob_idx - rob_head;
   endfunction

endpackage

// File: rtl/alu_iq_age_select.sv
// Combinational picker: grants the ready entry closest to the ROB head.
module alu_iq_age_select
   import alu_iq_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH
) (
   input  logic [DEPTH-1:0]                ready,
   input  logic [DEPTH-1:0][ROB_IDX_W-1:0] rob_idx,
   input  logic [ROB_IDX_W-1:0]            rob_head,
   output logic [DEPTH-1:0]                grant,
   output logic                            any_grant
);

   logic [ROB_IDX_W-1:0] best_age;

   // Linear scan keeping the smallest wrapped age seen so far among ready entries.
   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      best_age  = '1;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && (!any_grant || (rob_age(rob_idx[i], rob_head) < best_age))) begin
            grant     = '0;
            grant[i]  = 1'b1;
            any_grant = 1'b1;
            best_age  = rob_age(rob_idx[i], rob_head);
         end
      end
   end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: holds dispatched ops, wakes sources from the CDB and issues the oldest ready op.
module alu_issue_queue
   import alu_iq_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 disp_valid,
   output logic                 disp_ready,
   input  logic [4:0]           disp_opcode,
   input  logic [2:0]           disp_funct3,
   input  logic                 disp_funct7,
   input  logic [31:0]          disp_imm,
   input  logic [15:0]          disp_pc,
   input  logic [ROB_IDX_W-1:0] disp_rob_idx,
   input  logic                 disp_src1_rdy,
   input  logic                 disp_src2_rdy,
   input  logic [ROB_IDX_W-1:0] disp_src1_tag,
   input  logic [ROB_IDX_W-1:0] disp_src2_tag,
   input  logic [31:0]          disp_src1_data,
   input  logic [31:0]          disp_src2_data,
   input  logic                 cdb_valid,
   input  logic [ROB_IDX_W-1:0] cdb_rob_idx,
   input  logic [31:0]          cdb_data,
   input  logic [ROB_IDX_W-1:0] rob_head,
   input  logic                 flush,
   input  logic                 exe_stall,
   output logic                 alu_start,
   output logic [4:0]           iss_opcode,
   output logic [2:0]           iss_funct3,
   output logic                 iss_funct7,
   output logic [31:0]          iss_imm,
   output logic [15:0]          iss_pc,
   output logic [31:0]          iss_rs1_data,
   output logic [31:0]          iss_rs2_data,
   output logic [ROB_IDX_W-1:0] EXE_rob_idx
);

   iq_entry_t                      entry_q [DEPTH];
   logic [DEPTH-1:0]               valid_vec;
   logic [DEPTH-1:0]               ready_vec;
   logic [DEPTH-1:0]               alloc_oh;
   logic [DEPTH-1:0]               grant;
   logic [DEPTH-1:0][ROB_IDX_W-1:0] rob_idx_vec;
   logic                           any_grant;
   logic                           disp_fire;
   logic                           issue_fire;
   iq_entry_t                      disp_entry;
   iss_payload_t                   sel_payload;

   // Flatten per-entry status so the picker only ever sees registered state.
   always_comb begin
      valid_vec   = '0;
      ready_vec   = '0;
      rob_idx_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i]   = entry_q[i].valid;
         ready_vec[i]   = entry_q[i].valid && entry_q[i].src1_rdy && entry_q[i].src2_rdy;
         rob_idx_vec[i] = entry_q[i].rob_idx;
      end
   end

   assign disp_ready = ~&valid_vec;
   assign disp_fire  = disp_valid && disp_ready && !flush;
   assign issue_fire = any_grant && !exe_stall && !flush;

   alu_iq_age_select #(.DEPTH(DEPTH)) u_age_select (
      .ready     (ready_vec),
      .rob_idx   (rob_idx_vec),
      .rob_head  (rob_head),
      .grant     (grant),
      .any_grant (any_grant)
   );

   // Lowest-index free slot; the downward scan leaves the smallest index winning.
   always_comb begin
      alloc_oh = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_vec[i]) begin
            alloc_oh    = '0;
            alloc_oh[i] = 1'b1;
         end
      end
   end

   // Incoming entry, catching a CDB result that lands in the same cycle as dispatch.
   always_comb begin
      disp_entry           = '0;
      disp_entry.valid     = 1'b1;
      disp_entry.opcode    = disp_opcode;
      disp_entry.funct3    = disp_funct3;
      disp_entry.funct7    = disp_funct7;
      disp_entry.imm       = disp_imm;
      disp_entry.pc        = disp_pc;
      disp_entry.rob_idx   = disp_rob_idx;
      disp_entry.src1_rdy  = disp_src1_rdy;
      disp_entry.src1_tag  = disp_src1_tag;
      disp_entry.src1_data = disp_src1_data;
      disp_entry.src2_rdy  = disp_src2_rdy;
      disp_entry.src2_tag  = disp_src2_tag;
      disp_entry.src2_data = disp_src2_data;
      if (!disp_src1_rdy && cdb_valid && (cdb_rob_idx == disp_src1_tag)) begin
         disp_entry.src1_rdy  = 1'b1;
         disp_entry.src1_data = cdb_data;
      end
      if (!disp_src2_rdy && cdb_valid && (cdb_rob_idx == disp_src2_tag)) begin
         disp_entry.src2_rdy  = 1'b1;
         disp_entry.src2_data = cdb_data;
      end
   end

   // Gather the granted entry's fields for the issue register.
   always_comb begin
      sel_payload = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) begin
            sel_payload.opcode   = entry_q[i].opcode;
            sel_payload.funct3   = entry_q[i].funct3;
            sel_payload.funct7   = entry_q[i].funct7;
            sel_payload.imm      = entry_q[i].imm;
            sel_payload.pc       = entry_q[i].pc;
            sel_payload.rob_idx  = entry_q[i].rob_idx;
            sel_payload.rs1_data = entry_q[i].src1_data;
            sel_payload.rs2_data = entry_q[i].src2_data;
         end
      end
   end

   // Entry storage: reset/flush clear everything, otherwise free on issue, wake on CDB, fill on dispatch.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i].valid <= 1'b0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entry_q[i].valid) begin
               if (issue_fire && grant[i]) begin
                  entry_q[i].valid <= 1'b0;
               end else begin
                  if (cdb_valid && !entry_q[i].src1_rdy && (entry_q[i].src1_tag == cdb_rob_idx)) begin
                     entry_q[i].src1_rdy  <= 1'b1;
                     entry_q[i].src1_data <= cdb_data;
                  end
                  if (cdb_valid && !entry_q[i].src2_rdy && (entry_q[i].src2_tag == cdb_rob_idx)) begin
                     entry_q[i].src2_rdy  <= 1'b1;
                     entry_q[i].src2_data <= cdb_data;
                  end
               end
            end else if (disp_fire && alloc_oh[i]) begin
               entry_q[i] <= disp_entry;
            end
         end
      end
   end

   // Issue register: holds under stall, drops the valid on flush, keeps data when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_start    <= 1'b0;
         iss_opcode   <= '0;
         iss_funct3   <= '0;
         iss_funct7   <= 1'b0;
         iss_imm      <= '0;
         iss_pc       <= '0;
         iss_rs1_data <= '0;
         iss_rs2_data <= '0;
         EXE_rob_idx  <= '0;
      end else if (flush) begin
         alu_start <= 1'b0;
      end else if (!exe_stall) begin
         alu_start <= any_grant;
         if (any_grant) begin
            iss_opcode   <= sel_payload.opcode;
            iss_funct3   <= sel_payload.funct3;
            iss_funct7   <= sel_payload.funct7;
            iss_imm      <= sel_payload.imm;
            iss_pc       <= sel_payload.pc;
            iss_rs1_data <= sel_payload.rs1_data;
            iss_rs2_data <= sel_payload.rs2_data;
            EXE_rob_idx  <= sel_payload.rob_idx;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: a cycle table for the core flow plus hand sequences for corner cases.
module tb_alu_issue_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        disp_valid;
   logic        disp_ready;
   logic [4:0]  disp_opcode;
   logic [2:0]  disp_funct3;
   logic        disp_funct7;
   logic [31:0] disp_imm;
   logic [15:0] disp_pc;
   logic [2:0]  disp_rob_idx;
   logic        disp_src1_rdy, disp_src2_rdy;
   logic [2:0]  disp_src1_tag, disp_src2_tag;
   logic [31:0] disp_src1_data, disp_src2_data;
   logic        cdb_valid;
   logic [2:0]  cdb_rob_idx;
   logic [31:0] cdb_data;
   logic [2:0]  rob_head;
   logic        flush;
   logic        exe_stall;
   logic        alu_start;
   logic [4:0]  iss_opcode;
   logic [2:0]  iss_funct3;
   logic        iss_funct7;
   logic [31:0] iss_imm;
   logic [15:0] iss_pc;
   logic [31:0] iss_rs1_data, iss_rs2_data;
   logic [2:0]  EXE_rob_idx;

   int n_checks = 0;
   int n_fail   = 0;
   logic [2:0] cur_head = 3'd0;

   // One table row: inputs for a cycle and the outputs expected just after its edge.
   typedef struct {
      logic        dv;
      logic [2:0]  rob;
      logic        s1r;
      logic [2:0]  s1t;
      logic [31:0] s1d;
      logic        s2r;
      logic [2:0]  s2t;
      logic [31:0] s2d;
      logic        cv;
      logic [2:0]  ci;
      logic [31:0] cd;
      logic [2:0]  head;
      logic        stall;
      logic        fl;
      logic        e_start;
      logic [2:0]  e_rob;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic        e_ready;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   alu_issue_queue #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .disp_valid     (disp_valid),
      .disp_ready     (disp_ready),
      .disp_opcode    (disp_opcode),
      .disp_funct3    (disp_funct3),
      .disp_funct7    (disp_funct7),
      .disp_imm       (disp_imm),
      .disp_pc        (disp_pc),
      .disp_rob_idx   (disp_rob_idx),
      .disp_src1_rdy  (disp_src1_rdy),
      .disp_src2_rdy  (disp_src2_rdy),
      .disp_src1_tag  (disp_src1_tag),
      .disp_src2_tag  (disp_src2_tag),
      .disp_src1_data (disp_src1_data),
      .disp_src2_data (disp_src2_data),
      .cdb_valid      (cdb_valid),
      .cdb_rob_idx    (cdb_rob_idx),
      .cdb_data       (cdb_data),
      .rob_head       (rob_head),
      .flush          (flush),
      .exe_stall      (exe_stall),
      .alu_start      (alu_start),
      .iss_opcode     (iss_opcode),
      .iss_funct3     (iss_funct3),
      .iss_funct7     (iss_funct7),
      .iss_imm        (iss_imm),
      .iss_pc         (iss_pc),
      .iss_rs1_data   (iss_rs1_data),
      .iss_rs2_data   (iss_rs2_data),
      .EXE_rob_idx    (EXE_rob_idx)
   );

   // Op fields are a fixed function of the ROB tag so an issued op can be recognised.
   function automatic logic [56:0] op_fields(input logic [2:0] rob);
      return {5'(rob) + 5'd3, rob, rob[0], 32'h1000 + 32'(rob), 16'h100 + 16'(rob)};
   endfunction

   task automatic setIdle();
      disp_valid = 1'b0;
      {disp_opcode, disp_funct3, disp_funct7, disp_imm, disp_pc} = '0;
      disp_rob_idx = '0;
      disp_src1_rdy = 1'b0; disp_src1_tag = '0; disp_src1_data = '0;
      disp_src2_rdy = 1'b0; disp_src2_tag = '0; disp_src2_data = '0;
      cdb_valid = 1'b0; cdb_rob_idx = '0; cdb_data = '0;
      rob_head = cur_head;
      flush = 1'b0;
      exe_stall = 1'b0;
   endtask

   task automatic driveDispatch(input logic [2:0] rob, input logic s1r, input logic [2:0] s1t,
                                input logic [31:0] s1d, input logic s2r, input logic [2:0] s2t,
                                input logic [31:0] s2d);
      disp_valid = 1'b1;
      disp_rob_idx = rob;
      {disp_opcode, disp_funct3, disp_funct7, disp_imm, disp_pc} = op_fields(rob);
      disp_src1_rdy = s1r; disp_src1_tag = s1t; disp_src1_data = s1d;
      disp_src2_rdy = s2r; disp_src2_tag = s2t; disp_src2_data = s2d;
   endtask

   task automatic driveCdb(input logic [2:0] idx, input logic [31:0] data);
      cdb_valid = 1'b1;
      cdb_rob_idx = idx;
      cdb_data = data;
   endtask

   task automatic clockCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic e_start, input logic [2:0] e_rob,
                              input logic [31:0] e_rs1, input logic [31:0] e_rs2, input logic e_ready);
      checkVal({name, ".alu_start"}, 64'(alu_start), 64'(e_start));
      checkVal({name, ".disp_ready"}, 64'(disp_ready), 64'(e_ready));
      if (e_start) begin
         checkVal({name, ".EXE_rob_idx"}, 64'(EXE_rob_idx), 64'(e_rob));
         checkVal({name, ".iss_rs1_data"}, 64'(iss_rs1_data), 64'(e_rs1));
         checkVal({name, ".iss_rs2_data"}, 64'(iss_rs2_data), 64'(e_rs2));
         checkVal({name, ".op_fields"},
                  64'({iss_opcode, iss_funct3, iss_funct7, iss_imm, iss_pc}), 64'(op_fields(e_rob)));
      end
   endtask

   task automatic stepCheck(input string name, input logic e_start, input logic [2:0] e_rob,
                            input logic [31:0] e_rs1, input logic [31:0] e_rs2, input logic e_ready);
      clockCycle();
      checkOutput(name, e_start, e_rob, e_rs1, e_rs2, e_ready);
      setIdle();
   endtask

   task automatic applyStimulus(input vec_t v);
      setIdle();
      if (v.dv) driveDispatch(v.rob, v.s1r, v.s1t, v.s1d, v.s2r, v.s2t, v.s2d);
      if (v.cv) driveCdb(v.ci, v.cd);
      rob_head = v.head;
      exe_stall = v.stall;
      flush = v.fl;
      clockCycle();
   endtask

   // Bail out rather than hang if something stops the clock loop.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // dv rob s1r s1t s1d s2r s2t s2d | cv ci cd | head stall fl | e_start e_rob e_rs1 e_rs2 e_ready
      vecs.push_back('{1, 2, 1, 0, 32'h11, 1, 0, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h11, 32'h22, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 1, 0, 5, 0, 1, 0, 32'h102, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 7, 0, 5, 0, 1, 0, 32'h702, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h5555, 6, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 1, 7, 32'h5555, 32'h702, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 1, 1, 32'h5555, 32'h102, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 4, 0, 3, 0, 1, 0, 32'h402, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 3, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 4, 32'hDEADBEEF, 32'h402, 1});
      vecs.push_back('{1, 5, 0, 2, 0, 0, 2, 0, 1, 2, 32'hCAFEF00D, 3, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 5, 32'hCAFEF00D, 32'hCAFEF00D, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 6, 0, 1, 0, 1, 1, 32'h602, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h99, 0, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1111, 0, 0, 0, 0, 0, 0, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h1111, 32'h602, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});

      // Reset state
      setIdle();
      rst = 1'b1;
      clockCycle();
      clockCycle();
      checkVal("reset.alu_start", 64'(alu_start), 64'd0);
      checkVal("reset.disp_ready", 64'(disp_ready), 64'd1);
      checkVal("reset.EXE_rob_idx", 64'(EXE_rob_idx), 64'd0);
      checkVal("reset.iss_data", 64'({iss_rs1_data, iss_rs2_data}), 64'd0);
      checkVal("reset.op_fields", 64'({iss_opcode, iss_funct3, iss_funct7, iss_imm, iss_pc}), 64'd0);
      rst = 1'b0;

      // Basic issue latency, wrap-around age, wakeup and same-cycle CDB capture
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_rob,
                     vecs[i].e_rs1, vecs[i].e_rs2, vecs[i].e_ready);
      end
      cur_head = 3'd0;
      setIdle();

      // Fill all four slots, try an extra dispatch, then drain
      for (int r = 0; r < 4; r++) begin
         driveDispatch(3'(r), 1'b0, 3'd7, 32'h0, 1'b1, 3'd0, 32'(r));
         stepCheck("full_fill", 1'b0, 3'd0, 32'h0, 32'h0, (r < 3));
      end
      driveDispatch(3'd4, 1'b1, 3'd0, 32'h44, 1'b1, 3'd0, 32'h45);
      stepCheck("full_extra", 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      driveCdb(3'd7, 32'h77);
      stepCheck("full_wake", 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      stepCheck("full_issue0", 1'b1, 3'd0, 32'h77, 32'h0, 1'b1);
      for (int r = 1; r < 4; r++) begin
         stepCheck("full_drain", 1'b1, 3'(r), 32'h77, 32'(r), 1'b1);
      end
      stepCheck("full_empty", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

      // Three-cycle stall with dispatch continuing underneath
      for (int r = 1; r < 4; r++) begin
         driveDispatch(3'(r), 1'b0, 3'd6, 32'h0, 1'b1, 3'd0, 32'h20 + 32'(r));
         stepCheck("stall_fill", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      end
      driveCdb(3'd6, 32'h66);
      stepCheck("stall_wake", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      stepCheck("stall_first", 1'b1, 3'd1, 32'h66, 32'h21, 1'b1);
      for (int k = 0; k < 3; k++) begin
         exe_stall = 1'b1;
         if (k == 0) driveDispatch(3'd4, 1'b1, 3'd0, 32'h44, 1'b1, 3'd0, 32'h45);
         stepCheck("stall_hold", 1'b1, 3'd1, 32'h66, 32'h21, 1'b1);
      end
      stepCheck("stall_rel2", 1'b1, 3'd2, 32'h66, 32'h22, 1'b1);
      stepCheck("stall_rel3", 1'b1, 3'd3, 32'h66, 32'h23, 1'b1);
      stepCheck("stall_rel4", 1'b1, 3'd4, 32'h44, 32'h45, 1'b1);
      stepCheck("stall_empty", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

      // Flush with three waiting entries, a stalled issue, dispatch and wakeup all at once
      driveDispatch(3'd1, 1'b1, 3'd0, 32'h31, 1'b1, 3'd0, 32'h32);
      stepCheck("flush_d1", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      driveDispatch(3'd2, 1'b0, 3'd5, 32'h0, 1'b1, 3'd0, 32'h42);
      stepCheck("flush_d2", 1'b1, 3'd1, 32'h31, 32'h32, 1'b1);
      exe_stall = 1'b1;
      driveDispatch(3'd3, 1'b0, 3'd5, 32'h0, 1'b1, 3'd0, 32'h43);
      stepCheck("flush_d3", 1'b1, 3'd1, 32'h31, 32'h32, 1'b1);
      exe_stall = 1'b1;
      driveDispatch(3'd0, 1'b0, 3'd5, 32'h0, 1'b1, 3'd0, 32'h40);
      stepCheck("flush_d0", 1'b1, 3'd1, 32'h31, 32'h32, 1'b1);
      flush = 1'b1;
      exe_stall = 1'b1;
      driveDispatch(3'd4, 1'b1, 3'd0, 32'h44, 1'b1, 3'd0, 32'h45);
      driveCdb(3'd5, 32'h55);
      clockCycle();
      checkOutput("flush_now", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      checkVal("flush_hold_rob", 64'(EXE_rob_idx), 64'd1);
      setIdle();
      driveCdb(3'd5, 32'h55);
      stepCheck("flush_after", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         stepCheck("flush_quiet", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      end

      // Reset arriving mid-operation beats stall, dispatch and wakeup
      driveDispatch(3'd2, 1'b1, 3'd0, 32'h12, 1'b1, 3'd0, 32'h13);
      stepCheck("rst_d2", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      stepCheck("rst_issue", 1'b1, 3'd2, 32'h12, 32'h13, 1'b1);
      exe_stall = 1'b1;
      driveDispatch(3'd3, 1'b1, 3'd0, 32'h14, 1'b1, 3'd0, 32'h15);
      stepCheck("rst_stall", 1'b1, 3'd2, 32'h12, 32'h13, 1'b1);
      rst = 1'b1;
      exe_stall = 1'b1;
      driveDispatch(3'd5, 1'b1, 3'd0, 32'h16, 1'b1, 3'd0, 32'h17);
      driveCdb(3'd3, 32'h99);
      clockCycle();
      checkOutput("rst_mid", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      checkVal("rst_mid.EXE_rob_idx", 64'(EXE_rob_idx), 64'd0);
      checkVal("rst_mid.iss_rs1_data", 64'(iss_rs1_data), 64'd0);
      rst = 1'b0;
      setIdle();
      for (int k = 0; k < 2; k++) begin
         stepCheck("rst_quiet", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, 2..8).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 disp_valid  in  1  dispatch request.
REQ-005 disp_ready  out  1  at least one free entry.
REQ-006 disp_opcode / disp_funct3 / disp_funct7  in  5/3/1  decoded ALU operation.
REQ-007 disp_imm / disp_pc  in  32/16  immediate, instruction PC.
REQ-008 disp_rob_idx  in  3  destination ROB tag.
REQ-009 disp_src1_rdy / disp_src2_rdy  in  1 each  operand already available.
REQ-010 disp_src1_tag / disp_src2_tag  in  3 each  producer ROB tag when not available.
REQ-011 disp_src1_data / disp_src2_data  in  32 each  operand value when available.
REQ-012 cdb_valid / cdb_rob_idx / cdb_data  in  1/3/32  result broadcast.
REQ-013 rob_head  in  3  ROB index of oldest in-flight instruction.
REQ-014 flush  in  1  mispredict flush.
REQ-015 exe_stall  in  1  execute stage cannot accept a new op.
REQ-016 alu_start  out  1  registered issue valid to ALU.
REQ-017 iss_opcode / iss_funct3 / iss_funct7 / iss_imm / iss_pc  out  5/3/1/32/16  registered op fields.
REQ-018 iss_rs1_data / iss_rs2_data  out  32 each  registered operands.
REQ-019 EXE_rob_idx  out  3  registered ROB tag of issued op.

Function
REQ-020 Each entry SHALL hold valid, op fields, rob_idx, and per source rdy/tag/data; queue SHALL NOT interpret opcode (dispatcher sets src2_rdy=1 for immediate forms).
REQ-021 Dispatch SHALL be accepted iff disp_valid && disp_ready && !flush, written to the lowest-index free entry at the clock edge.
REQ-022 disp_ready SHALL derive from registered state only: 0 when all DEPTH entries valid, no same-cycle credit from an issuing entry.
REQ-023 Wakeup: when cdb_valid, every valid entry source with rdy=0 and tag==cdb_rob_idx SHALL set rdy=1 and capture cdb_data at the edge.
REQ-024 A dispatching source with rdy=0 whose tag matches a same-cycle CDB broadcast SHALL be stored ready with cdb_data.
REQ-025 Entry ready = valid && src1_rdy && src2_rdy; select SHALL pick the ready entry with smallest age (rob_idx - rob_head) mod 8 (3-bit wrap).
REQ-026 When !exe_stall, selected entry SHALL load the issue register and be freed at the same edge; alu_start=1 next cycle; no ready entry -> alu_start=0.
REQ-027 When exe_stall=1, issue register and alu_start SHALL hold and no entry SHALL be freed; wakeup and dispatch continue.
REQ-028 Latency: op dispatched ready in cycle t, or woken by CDB in cycle t, SHALL assert alu_start no earlier than cycle t+2 (no CDB-to-issue bypass).
REQ-029 Flush SHALL take priority over all events: all entries invalid, alu_start=0 next cycle, same-cycle dispatch discarded, exe_stall ignored.
REQ-030 Data outputs (iss_*, EXE_rob_idx) SHALL hold last issued values when alu_start=0.

Reset
REQ-031 On rst: all entries invalid, alu_start=0, all iss_* and EXE_rob_idx=0, disp_ready=1 the following cycle.
REQ-032 rst asserted mid-operation SHALL discard all entries and any stalled issue, overriding flush, dispatch and wakeup.

Structure
REQ-033 Shared package alu_iq_pkg SHALL hold ROB_IDX_W=3, DEPTH default and entry struct iq_entry_t; opcode constants stay in the existing define header.
REQ-034 Sub-module alu_iq_age_select (combinational oldest-ready picker: ready vector, rob_idx per entry, rob_head -> one-hot grant, any-grant).

Verification
REQ-035 Dispatch ready op rob_idx=2 at t -> alu_start=1, EXE_rob_idx=2, operands as dispatched, at t+2.
REQ-036 rob_head=6, ready entries rob_idx 7 and 1 -> 7 issues first, 1 next cycle (wrap-around age).
REQ-037 Entry src1 tag=3 not ready; cdb_valid, rob_idx=3, data=0xDEADBEEF at t -> issue at t+2 with iss_rs1_data=0xDEADBEEF.
REQ-038 Fill 4 entries -> disp_ready=0; extra disp_valid ignored; after one issue disp_ready=1 next cycle.
REQ-039 exe_stall=1 for 3 cycles with alu_start=1 -> outputs held, queue occupancy unchanged; release -> next oldest issues.
REQ-040 flush with 3 valid entries plus concurrent dispatch -> alu_start=0 and disp_ready=1 next cycle, no later issue of flushed ops.
